// File: rtl/spi_slave_gen.sv
// spi_slave_gen: SPI slave front-end, deserialises cmd/addr/data words from MOSI
// and serialises back-end read data onto MISO, with abort detection.
module spi_slave_gen #(
  parameter int DATA_W    = 8,
  parameter int CMD_W     = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    SS_n,
  input  logic                    MOSI,
  output logic                    MISO,
  output logic [CMD_W+DATA_W-1:0] rx_data,
  output logic                    rx_valid,
  input  logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic                    frame_err,
  output logic                    busy
);
  localparam int RX_W = CMD_W + DATA_W;
  localparam int CW   = $clog2(RX_W + 1);
  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, DONE} state_t;
  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [RX_W-1:0]   r_sr, w_sr;
  logic [DATA_W-1:0] r_tx;
  logic              r_rd_pending;
  logic              w_rx, w_last, w_abort, w_load_tx, w_send, w_send_end;
  always_ff @(posedge clk) r_state <= !rst_n ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    if (w_abort) w_next = IDLE;
    else case (r_state)
      IDLE:      w_next = SS_n ? IDLE : CHK_CMD;
      CHK_CMD:   w_next = !MOSI ? WRITE : r_rd_pending ? READ_DATA : READ_ADD;
      WRITE,
      READ_ADD:  w_next = w_last ? DONE : r_state;
      READ_DATA: w_next = w_last ? WAIT_TX : READ_DATA;
      WAIT_TX:   w_next = tx_valid ? SEND : WAIT_TX;
      SEND:      w_next = w_send_end ? DONE : SEND;
      DONE:      w_next = SS_n ? IDLE : DONE;
      default:   w_next = IDLE;
    endcase
  end
  always_comb begin
    tx_ready   = r_state == WAIT_TX;
    busy       = r_state != IDLE;
    w_rx       = r_state == WRITE || r_state == READ_ADD || r_state == READ_DATA;
    w_abort    = SS_n && r_state != IDLE && r_state != DONE;
    w_last     = w_rx && !SS_n && r_cnt == CW'(1);
    w_load_tx  = tx_ready && tx_valid && !SS_n;
    w_send     = r_state == SEND && !SS_n && r_cnt != '0;
    w_send_end = r_state == SEND && !SS_n && r_cnt == '0;
    w_sr       = MSB_FIRST != 0 ? {r_sr[RX_W-2:0], MOSI} : {MOSI, r_sr[RX_W-1:1]};
  end
  // r_cnt counts payload bits while receiving and remaining MISO bits while sending
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      MISO         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
      r_rd_pending <= 1'b0;
      r_sr         <= '0;
      r_tx         <= '0;
      r_cnt        <= '0;
    end else begin
      rx_valid  <= w_last;
      frame_err <= w_abort;
      MISO      <= 1'b0;
      if (r_state == CHK_CMD) r_cnt <= CW'(RX_W);
      if (w_rx && !SS_n) begin
        r_cnt <= r_cnt - 1'b1;
        r_sr  <= w_sr;
      end
      if (w_last) rx_data <= w_sr;
      if (w_last && r_state == READ_ADD) r_rd_pending <= 1'b1;
      if (w_load_tx) begin
        MISO  <= MSB_FIRST != 0 ? tx_data[DATA_W-1] : tx_data[0];
        r_tx  <= MSB_FIRST != 0 ? tx_data << 1 : tx_data >> 1;
        r_cnt <= CW'(DATA_W - 1);
      end
      if (w_send) begin
        MISO  <= MSB_FIRST != 0 ? r_tx[DATA_W-1] : r_tx[0];
        r_tx  <= MSB_FIRST != 0 ? r_tx << 1 : r_tx >> 1;
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_send_end) r_rd_pending <= 1'b0;
    end
  end
endmodule
